wb_arbiter: RTL and testbench

- Writer-side companion to the register file. Owns the register file's single write port (we/rd/data).
- Merges two result sources onto that port:
  - the in-order pipeline writeback stream, which never accepts backpressure;
  - a multi-cycle execution unit (mul/div) result stream, which uses a valid/ready handshake.
- Multi-cycle results are held in a small FIFO until a free writeback slot exists.
- Drives a pending-destination mask and a starvation stall request to the hazard logic.

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_fifo.sv | 67 ++++++
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, writeback source encoding and the one-hot helper
// used by the writeback arbiter and its tracer.
package wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_MC   = 2'd2
  } wb_src_t;

  function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return XLEN'(1) << rd;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Multi-cycle result queue: synchronous push/pop, wrap-bit full/empty,
// and a per-entry valid/rd view for building the pending mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [REG_ADDR_W-1:0]       push_rd,
  input  logic [XLEN-1:0]             push_data,
  output logic                        full,
  output logic                        empty,
  output logic [REG_ADDR_W-1:0]       head_rd,
  output logic [XLEN-1:0]             head_data,
  output logic [DEPTH-1:0]            entry_vld,
  output logic [DEPTH*REG_ADDR_W-1:0] entry_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_rd   = rd_mem[rd_ptr[AW-1:0]];
  assign head_data = data_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      entry_vld <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr                      <= rd_ptr + PTR_ONE;
        entry_vld[rd_ptr[AW-1:0]]   <= 1'b0;
      end
      if (do_push) begin
        wr_ptr                      <= wr_ptr + PTR_ONE;
        entry_vld[wr_ptr[AW-1:0]]   <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; entry_vld qualifies every use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr[AW-1:0]]   <= push_rd;
      data_mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    assign entry_rd[i*REG_ADDR_W +: REG_ADDR_W] = rd_mem[i];
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port owner: pipeline writeback has strict priority,
// multi-cycle results queue in wb_fifo and raise pipe_stall when starved.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_wb_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wb_rd,
  input  logic [XLEN-1:0]       pipe_wb_data,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  mc_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wd,
  output logic [XLEN-1:0]       pending_mask,
  output logic                  pipe_stall
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(STARVE_LIMIT - 1);

  logic                        full;
  logic                        empty;
  logic [REG_ADDR_W-1:0]       head_rd;
  logic [XLEN-1:0]             head_data;
  logic [DEPTH-1:0]            entry_vld;
  logic [DEPTH*REG_ADDR_W-1:0] entry_rd;
  logic                        pipe_take;
  logic                        push;
  logic                        pop;
  logic [AGE_W-1:0]            age;
  wb_src_t                     sel;

  assign mc_ready  = !full;
  assign pipe_take = pipe_wb_valid && (pipe_wb_rd != '0);
  assign push      = mc_valid && !full && (mc_rd != '0);
  assign pop       = (sel == WB_MC);

  always_comb begin
    sel = WB_NONE;
    if (pipe_take)   sel = WB_PIPE;
    else if (!empty) sel = WB_MC;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_rd   (mc_rd),
    .push_data (mc_data),
    .full      (full),
    .empty     (empty),
    .head_rd   (head_rd),
    .head_data (head_data),
    .entry_vld (entry_vld),
    .entry_rd  (entry_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wd      <= '0;
      age        <= '0;
      pipe_stall <= 1'b0;
    end else begin
      case (sel)
        WB_PIPE: begin
          rf_we <= 1'b1;
          rf_rd <= pipe_wb_rd;
          rf_wd <= pipe_wb_data;
        end
        WB_MC: begin
          rf_we <= 1'b1;
          rf_rd <= head_rd;
          rf_wd <= head_data;
        end
        default: rf_we <= 1'b0;
      endcase

      if (empty || pop)      age <= '0;
      else if (age != AGE_MAX) age <= age + 1'b1;

      // Registered one cycle early so the bubble lines up with the next slot.
      pipe_stall <= full || ((age >= AGE_THR) && !pop);
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) pending_mask = pending_mask | rd_onehot(entry_rd[i*REG_ADDR_W +: REG_ADDR_W]);
    end
    if (rf_we) pending_mask = pending_mask | rd_onehot(rf_rd);
    pending_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset corner sequences and
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] pending_mask;
  logic        pipe_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_rd    (pipe_wb_rd),
    .pipe_wb_data  (pipe_wb_data),
    .mc_valid      (mc_valid),
    .mc_rd         (mc_rd),
    .mc_data       (mc_data),
    .mc_ready      (mc_ready),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wd         (rf_wd),
    .pending_mask  (pending_mask),
    .pipe_stall    (pipe_stall)
  );

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        rdy;
    logic        st;
    logic [31:0] mask;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[25];

  // Reference model state
  ent_t        q[$];
  int          m_age;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic we, input logic [4:0] rd, input logic [31:0] wd,
                              input logic rdy, input logic st, input logic [31:0] mask);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.we = we; v.rd = rd; v.wd = wd; v.rdy = rdy; v.st = st; v.mask = mask;
    return v;
  endfunction

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_wb_valid = pv; pipe_wb_rd = prd; pipe_wb_data = pd;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
  endtask

  task automatic model_reset();
    q.delete();
    m_age = 0; m_we = 1'b0; m_rd = '0; m_wd = '0; m_st = 1'b0;
  endtask

  // One clock of the reference behaviour, evaluated from pre-edge state.
  task automatic model_step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                            input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bit   is_full  = (q.size() == DEPTH);
    bit   is_empty = (q.size() == 0);
    bit   take     = pv && (prd != 0);
    bit   do_pop   = !take && !is_empty;
    bit   do_push  = mv && !is_full && (mrd != 0);
    ent_t e;
    m_st = is_full || ((m_age >= LIMIT - 1) && !do_pop);
    if (take) begin
      m_we = 1'b1; m_rd = prd; m_wd = pd;
    end else if (do_pop) begin
      m_we = 1'b1; m_rd = q[0].rd; m_wd = q[0].data;
    end else begin
      m_we = 1'b0;
    end
    if (is_empty || do_pop) m_age = 0;
    else if (m_age < LIMIT) m_age = m_age + 1;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.rd = mrd; e.data = md;
      q.push_back(e);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    if (m_we) m[m_rd] = 1'b1;
    return m;
  endfunction

  initial begin
    tbl[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0, 32'h0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 0, 32'h20);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,            0, 5, 32'hDEADBEEF, 1, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0,            1, 7, 32'h12345678, 0, 5, 32'hDEADBEEF, 1, 0, 32'h80);
    tbl[4]  = mk(0, 0, 0,            0, 0, 0,            1, 7, 32'h12345678, 1, 0, 32'h80);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,            0, 7, 32'h12345678, 1, 0, 32'h0);
    tbl[6]  = mk(1, 1, 32'h101,      1, 3, 32'h333,      1, 1, 32'h101,      1, 0, 32'h0A);
    tbl[7]  = mk(1, 2, 32'h102,      0, 0, 0,            1, 2, 32'h102,      1, 0, 32'h0C);
    tbl[8]  = mk(1, 4, 32'h104,      0, 0, 0,            1, 4, 32'h104,      1, 0, 32'h18);
    tbl[9]  = mk(1, 5, 32'h105,      0, 0, 0,            1, 5, 32'h105,      1, 0, 32'h28);
    tbl[10] = mk(1, 6, 32'h106,      0, 0, 0,            1, 6, 32'h106,      1, 1, 32'h48);
    tbl[11] = mk(1, 10, 32'h10A,     0, 0, 0,            1, 10, 32'h10A,     1, 1, 32'h408);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,            1, 3, 32'h333,      1, 0, 32'h08);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,            0, 3, 32'h333,      1, 0, 32'h0);
    tbl[14] = mk(1, 1, 32'h201,      1, 8, 32'h888,      1, 1, 32'h201,      1, 0, 32'h102);
    tbl[15] = mk(1, 2, 32'h202,      1, 9, 32'h999,      1, 2, 32'h202,      0, 0, 32'h304);
    tbl[16] = mk(1, 4, 32'h204,      1, 11, 32'hBBB,     1, 4, 32'h204,      0, 1, 32'h310);
    tbl[17] = mk(0, 0, 0,            1, 11, 32'hBBB,     1, 8, 32'h888,      1, 1, 32'h300);
    tbl[18] = mk(0, 0, 0,            1, 11, 32'hBBB,     1, 9, 32'h999,      1, 0, 32'hA00);
    tbl[19] = mk(0, 0, 0,            0, 0, 0,            1, 11, 32'hBBB,     1, 0, 32'h800);
    tbl[20] = mk(0, 0, 0,            0, 0, 0,            0, 11, 32'hBBB,     1, 0, 32'h0);
    tbl[21] = mk(0, 0, 0,            1, 0, 32'hFFF,      0, 11, 32'hBBB,     1, 0, 32'h0);
    tbl[22] = mk(1, 1, 32'h301,      1, 4, 32'h444,      1, 1, 32'h301,      1, 0, 32'h12);
    tbl[23] = mk(1, 0, 32'h555,      0, 0, 0,            1, 4, 32'h444,      1, 0, 32'h10);
    tbl[24] = mk(0, 0, 0,            0, 0, 0,            0, 4, 32'h444,      1, 0, 32'h0);

    // Reset, then idle
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", {31'b0, rf_we}, 32'h0);
    chk("reset_rf_rd", {27'b0, rf_rd}, 32'h0);
    chk("reset_rf_wd", rf_wd, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_rf_we", {31'b0, rf_we}, 32'h0);
      chk("idle_mc_ready", {31'b0, mc_ready}, 32'h1);
      chk("idle_mask", pending_mask, 32'h0);
      chk("idle_stall", {31'b0, pipe_stall}, 32'h0);
    end

    // Directed vector table
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].pv, tbl[i].prd, tbl[i].pd, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rf_we", i), {31'b0, rf_we}, {31'b0, tbl[i].we});
      chk($sformatf("vec%0d_rf_rd", i), {27'b0, rf_rd}, {27'b0, tbl[i].rd});
      chk($sformatf("vec%0d_rf_wd", i), rf_wd, tbl[i].wd);
      chk($sformatf("vec%0d_mc_ready", i), {31'b0, mc_ready}, {31'b0, tbl[i].rdy});
      chk($sformatf("vec%0d_stall", i), {31'b0, pipe_stall}, {31'b0, tbl[i].st});
      chk($sformatf("vec%0d_mask", i), pending_mask, tbl[i].mask);
    end

    // Async reset pulse with an entry queued
    drive(1, 1, 32'h401, 1, 12, 32'hCCC);
    @(posedge clk); #1;
    chk("preq_mask", pending_mask, 32'h1002);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rf_we", {31'b0, rf_we}, 32'h0);
    chk("arst_mask", pending_mask, 32'h0);
    chk("arst_mc_ready", {31'b0, mc_ready}, 32'h1);
    chk("arst_stall", {31'b0, pipe_stall}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_rf_we", {31'b0, rf_we}, 32'h0);
    chk("postrst_mask", pending_mask, 32'h0);

    // Randomized traffic against the reference model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        pv, mv;
      logic [4:0]  prd, mrd;
      logic [31:0] pd, md;
      pv  = ($urandom_range(0, 99) < 65);
      prd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) prd = 5'd0;
      pd  = $urandom;
      mv  = ($urandom_range(0, 99) < 50);
      mrd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) mrd = 5'd0;
      md  = $urandom;
      drive(pv, prd, pd, mv, mrd, md);
      @(posedge clk); #1;
      model_step(pv, prd, pd, mv, mrd, md);
      chk("rnd_rf_we", {31'b0, rf_we}, {31'b0, m_we});
      chk("rnd_rf_rd", {27'b0, rf_rd}, {27'b0, m_rd});
      chk("rnd_rf_wd", rf_wd, m_wd);
      chk("rnd_mc_ready", {31'b0, mc_ready}, {31'b0, (q.size() < DEPTH)});
      chk("rnd_stall", {31'b0, pipe_stall}, {31'b0, m_st});
      chk("rnd_mask", pending_mask, model_mask());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
